// File: rtl/axi_mem_responder.sv
// Word-addressed RAM behind independent read and write burst engines for the
// data cache's request interface; reads return the pre-write word on same-cycle hits.
module axi_mem_responder #(
    parameter int MEM_AW    = 12,
    parameter int READ_LAT  = 2,
    parameter int WRESP_LAT = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        r_req,
    input  logic [31:0] r_addr,
    input  logic [7:0]  r_length,
    input  logic [2:0]  r_size,
    output logic        r_rdy,
    input  logic        r_data_ready,
    output logic [31:0] r_data,
    output logic        r_valid,
    output logic        r_last,
    input  logic        w_req,
    input  logic [31:0] w_addr,
    input  logic [7:0]  w_length,
    input  logic [2:0]  w_size,
    output logic        w_rdy,
    input  logic [31:0] w_data,
    input  logic [3:0]  w_strb,
    input  logic        w_valid,
    input  logic        w_last,
    output logic        w_ready,
    output logic        w_finish
);

    // Handshakes: a request is taken in the cycle *_rdy is high (requester holds
    // *_req until then); a beat moves in any cycle where valid and ready are both high.
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    r_state_e    r_state_q, r_state_d;
    logic [31:0] r_addr_q, r_addr_d;
    logic [7:0]  r_len_q, r_len_d;
    logic [2:0]  r_size_q, r_size_d;
    logic [7:0]  r_cnt_q, r_cnt_d;
    logic [15:0] r_lat_q, r_lat_d;

    w_state_e    w_state_q, w_state_d;
    logic [31:0] w_addr_q, w_addr_d;
    logic [7:0]  w_len_q, w_len_d;
    logic [2:0]  w_size_q, w_size_d;
    logic [7:0]  w_cnt_q, w_cnt_d;
    logic [15:0] w_lat_q, w_lat_d;
    logic        w_we;

    logic [31:0] mem_q [2**MEM_AW];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state_q <= R_IDLE;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_size_q  <= '0;
            r_cnt_q   <= '0;
            r_lat_q   <= '0;
            w_state_q <= W_IDLE;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_size_q  <= '0;
            w_cnt_q   <= '0;
            w_lat_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_size_q  <= r_size_d;
            r_cnt_q   <= r_cnt_d;
            r_lat_q   <= r_lat_d;
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_size_q  <= w_size_d;
            w_cnt_q   <= w_cnt_d;
            w_lat_q   <= w_lat_d;
        end
    end

    // Contents survive reset; only the engines are cleared.
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_strb[b]) mem_q[w_addr_q[MEM_AW+1:2]][8*b +: 8] <= w_data[8*b +: 8];
            end
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_size_d  = r_size_q;
        r_cnt_d   = r_cnt_q;
        r_lat_d   = r_lat_q;
        r_rdy     = 1'b0;
        r_valid   = 1'b0;
        r_last    = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                r_rdy = r_req & rstn;
                if (r_rdy) begin
                    r_addr_d  = r_addr;
                    r_len_d   = r_length;
                    r_size_d  = r_size;
                    r_cnt_d   = '0;
                    r_lat_d   = 16'(READ_LAT);
                    r_state_d = (READ_LAT > 1) ? R_WAIT : R_BURST;
                end
            end
            R_WAIT: begin
                r_lat_d = r_lat_q - 16'd1;
                if (r_lat_q <= 16'd2) r_state_d = R_BURST;
            end
            R_BURST: begin
                r_valid = 1'b1;
                r_last  = (r_cnt_q == r_len_q);
                if (r_data_ready) begin
                    r_addr_d = r_addr_q + (32'd1 << r_size_q);
                    r_cnt_d  = r_cnt_q + 8'd1;
                    if (r_last) r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Combinational read of the current word gives read-before-write for free.
    assign r_data = r_valid ? mem_q[r_addr_q[MEM_AW+1:2]] : '0;

    always_comb begin
        w_state_d = w_state_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_size_d  = w_size_q;
        w_cnt_d   = w_cnt_q;
        w_lat_d   = w_lat_q;
        w_rdy     = 1'b0;
        w_ready   = 1'b0;
        w_finish  = 1'b0;
        w_we      = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                w_rdy = w_req & rstn;
                if (w_rdy) begin
                    w_addr_d  = w_addr;
                    w_len_d   = w_length;
                    w_size_d  = w_size;
                    w_cnt_d   = '0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    w_we     = 1'b1;
                    w_addr_d = w_addr_q + (32'd1 << w_size_q);
                    w_cnt_d  = w_cnt_q + 8'd1;
                    if (w_last || (w_cnt_q == w_len_q)) begin
                        w_lat_d   = 16'(WRESP_LAT);
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (w_lat_q == 16'd0) begin
                    w_finish  = 1'b1;
                    w_state_d = W_IDLE;
                end else begin
                    w_lat_d = w_lat_q - 16'd1;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Bench for axi_mem_responder: directed bursts plus randomized concurrent traffic,
// checked every cycle against a transaction-level memory model.
module tb_axi_mem_responder;
  localparam int MEM_AW = 12;
  localparam int READ_LAT = 2;
  localparam int WRESP_LAT = 1;
  localparam int DEPTH = 1 << MEM_AW;

  logic clk = 1'b0;
  logic rstn;
  logic r_req, r_rdy, r_data_ready, r_valid, r_last;
  logic [31:0] r_addr, r_data;
  logic [7:0] r_length;
  logic [2:0] r_size;
  logic w_req, w_rdy, w_valid, w_last, w_ready, w_finish;
  logic [31:0] w_addr, w_data;
  logic [7:0] w_length;
  logic [2:0] w_size;
  logic [3:0] w_strb;

  axi_mem_responder #(.MEM_AW(MEM_AW), .READ_LAT(READ_LAT), .WRESP_LAT(WRESP_LAT)) dut (
    .clk(clk), .rstn(rstn),
    .r_req(r_req), .r_addr(r_addr), .r_length(r_length), .r_size(r_size), .r_rdy(r_rdy),
    .r_data_ready(r_data_ready), .r_data(r_data), .r_valid(r_valid), .r_last(r_last),
    .w_req(w_req), .w_addr(w_addr), .w_length(w_length), .w_size(w_size), .w_rdy(w_rdy),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_last(w_last),
    .w_ready(w_ready), .w_finish(w_finish)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    failures++;
    $display("FAIL %s: no response within the cycle budget (cycle %0d)", name, cyc);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mem_m [DEPTH];
  logic [3:0]  kn_m [DEPTH] = '{default: 4'h0};
  bit          m_rd_busy = 0;
  int          m_rd_valid_at = 0, m_rd_len = 0, m_rd_size = 0, m_rd_beat = 0;
  logic [31:0] m_rd_addr = '0;
  int          m_wr_phase = 0, m_wr_fin_at = 0, m_wr_len = 0, m_wr_size = 0, m_wr_beat = 0;
  logic [31:0] m_wr_addr = '0;

  function automatic int widx(input logic [31:0] a);
    return int'(a[MEM_AW+1:2]);
  endfunction

  always @(negedge clk) begin : model_cmp
    logic e_rrdy, e_rvalid, e_rlast, e_wrdy, e_wready, e_wfin;
    logic [31:0] msk;
    int ri, wi;
    if (!rstn) begin
      chk("reset_ctrl_outputs", 32'({r_rdy, r_valid, r_last, w_rdy, w_ready, w_finish}), 32'h0);
      chk("reset_r_data", r_data, 32'h0);
      m_rd_busy = 0;
      m_wr_phase = 0;
    end else begin
      e_rrdy   = r_req && !m_rd_busy;
      e_rvalid = m_rd_busy && (cyc >= m_rd_valid_at);
      e_rlast  = e_rvalid && (m_rd_beat == m_rd_len);
      e_wrdy   = w_req && (m_wr_phase == 0);
      e_wready = (m_wr_phase == 1);
      e_wfin   = (m_wr_phase == 2) && (cyc == m_wr_fin_at);
      chk("r_rdy", 32'(r_rdy), 32'(e_rrdy));
      chk("r_valid", 32'(r_valid), 32'(e_rvalid));
      chk("r_last", 32'(r_last), 32'(e_rlast));
      chk("w_rdy", 32'(w_rdy), 32'(e_wrdy));
      chk("w_ready", 32'(w_ready), 32'(e_wready));
      chk("w_finish", 32'(w_finish), 32'(e_wfin));
      if (e_rvalid) begin
        ri = widx(m_rd_addr);
        msk = {{8{kn_m[ri][3]}}, {8{kn_m[ri][2]}}, {8{kn_m[ri][1]}}, {8{kn_m[ri][0]}}};
        if (msk != 32'h0) chk("r_data", r_data & msk, mem_m[ri] & msk);
      end else begin
        chk("r_data_idle", r_data, 32'h0);
      end
      // advance the model by the transfers that happen at the coming edge
      if (e_rrdy) begin
        m_rd_busy = 1;
        m_rd_addr = r_addr;
        m_rd_len = int'(r_length);
        m_rd_size = int'(r_size);
        m_rd_beat = 0;
        m_rd_valid_at = cyc + ((READ_LAT < 1) ? 1 : READ_LAT);
      end else if (e_rvalid && r_data_ready) begin
        if (m_rd_beat == m_rd_len) m_rd_busy = 0;
        else begin
          m_rd_beat++;
          m_rd_addr = m_rd_addr + (32'd1 << m_rd_size);
        end
      end
      if (e_wrdy) begin
        m_wr_phase = 1;
        m_wr_addr = w_addr;
        m_wr_len = int'(w_length);
        m_wr_size = int'(w_size);
        m_wr_beat = 0;
      end else if (m_wr_phase == 1 && w_valid) begin
        wi = widx(m_wr_addr);
        for (int b = 0; b < 4; b++) begin
          if (w_strb[b]) begin
            mem_m[wi][8*b +: 8] = w_data[8*b +: 8];
            kn_m[wi][b] = 1'b1;
          end
        end
        if (w_last || m_wr_beat == m_wr_len) begin
          m_wr_phase = 2;
          m_wr_fin_at = cyc + 1 + WRESP_LAT;
        end else begin
          m_wr_beat++;
          m_wr_addr = m_wr_addr + (32'd1 << m_wr_size);
        end
      end else if (e_wfin) begin
        m_wr_phase = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [31:0] rx_q [$];
  int rd_first, last_pos, wl_cyc, fin_cyc;

  // rmode: 0 always ready, 1 toggle 1,0,1,0, 2 random
  task automatic do_read(input logic [31:0] addr, input int len, input int size, input int rmode);
    int k;
    int acc;
    bit ok;
    bit done;
    rx_q.delete();
    last_pos = -1;
    rd_first = -1;
    r_addr = addr;
    r_length = 8'(len);
    r_size = 3'(size);
    r_req = 1'b1;
    ok = 0;
    k = 0;
    while (!ok && k < 200) begin
      @(negedge clk);
      if (r_rdy) ok = 1;
      k++;
    end
    acc = cyc;
    @(posedge clk);
    #1 r_req = 1'b0;
    if (!ok) tmo("read_accept");
    done = !ok;
    k = 0;
    while (!done) begin
      r_data_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ((k % 2) == 0) : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (r_valid && rd_first < 0) rd_first = cyc - acc;
      if (r_valid && r_data_ready) begin
        rx_q.push_back(r_data);
        if (r_last) begin
          done = 1;
          last_pos = rx_q.size();
        end
      end
      @(posedge clk);
      #1;
      k++;
      if (!done && k > 2000) begin
        tmo("read_burst");
        done = 1;
      end
    end
    r_data_ready = 1'b0;
  endtask

  // dmode: 0 base+step*i, 1 random; strb_fix 0 means random strobes; vmode 1 = random w_valid gaps
  task automatic do_write(input logic [31:0] addr, input int len, input int size, input int nbeats,
                          input bit send_last, input int dmode, input logic [31:0] base,
                          input logic [31:0] step, input logic [3:0] strb_fix, input int vmode,
                          input int delay);
    int k;
    int i;
    bit ok;
    wl_cyc = -1;
    fin_cyc = -1;
    w_addr = addr;
    w_length = 8'(len);
    w_size = 3'(size);
    w_req = 1'b1;
    ok = 0;
    k = 0;
    while (!ok && k < 200) begin
      @(negedge clk);
      if (w_rdy) ok = 1;
      k++;
    end
    @(posedge clk);
    #1 w_req = 1'b0;
    if (!ok) tmo("write_accept");
    else begin
      repeat (delay) begin
        @(posedge clk);
        #1;
      end
      i = 0;
      k = 0;
      while (i < nbeats && k < 2000) begin
        w_valid = (vmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        w_data = (dmode == 1) ? $urandom : base + step * 32'(i);
        w_strb = (strb_fix == 4'h0) ? 4'($urandom_range(0, 15)) : strb_fix;
        w_last = send_last && (i == nbeats - 1);
        @(negedge clk);
        if (w_valid && w_ready) begin
          if (i == nbeats - 1) wl_cyc = cyc;
          i++;
        end
        @(posedge clk);
        #1;
        k++;
      end
      w_valid = 1'b0;
      w_last = 1'b0;
      if (i < nbeats) tmo("write_beats");
      k = 0;
      while (fin_cyc < 0 && k < 50) begin
        @(negedge clk);
        if (w_finish) fin_cyc = cyc;
        k++;
      end
      if (fin_cyc < 0) tmo("write_finish");
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : main
    int cnt;
    int k;
    rstn = 1'b0;
    r_req = 1'b1;
    r_addr = 32'h0; r_length = 8'h0; r_size = 3'h0; r_data_ready = 1'b0;
    w_req = 1'b0; w_addr = 32'h0; w_length = 8'h0; w_size = 3'h0;
    w_data = 32'h0; w_strb = 4'h0; w_valid = 1'b0; w_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_r_rdy_literal", 32'(r_rdy), 32'h0);
    chk("rst_r_valid_literal", 32'(r_valid), 32'h0);
    chk("rst_w_finish_literal", 32'(w_finish), 32'h0);
    @(posedge clk);
    #1 r_req = 1'b0;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // preload and full-speed read
    do_write(32'h100, 15, 2, 16, 1, 0, 32'hA0, 32'h1, 4'hF, 0, 0);
    do_read(32'h100, 15, 2, 0);
    chk("rd1_beats", 32'(rx_q.size()), 32'd16);
    chk("rd1_latency", 32'(rd_first), 32'd2);
    chk("rd1_last_pos", 32'(last_pos), 32'd16);
    for (int i = 0; i < rx_q.size(); i++) chk("rd1_data", rx_q[i], 32'hA0 + 32'(i));

    // stalled read
    do_read(32'h100, 15, 2, 1);
    chk("rd2_beats", 32'(rx_q.size()), 32'd16);
    for (int i = 0; i < rx_q.size(); i++) chk("rd2_data", rx_q[i], 32'hA0 + 32'(i));

    // full write burst, response latency, read-back
    do_write(32'h200, 15, 2, 16, 1, 0, 32'h0, 32'h11, 4'hF, 0, 0);
    chk("wr_finish_latency", 32'(fin_cyc - wl_cyc), 32'd2);
    do_read(32'h200, 15, 2, 0);
    chk("rd3_beats", 32'(rx_q.size()), 32'd16);
    for (int i = 0; i < rx_q.size(); i++) chk("rd3_data", rx_q[i], 32'h11 * 32'(i));

    // byte-lane write into word 0xC0
    do_write(32'h300, 0, 2, 1, 1, 0, 32'h01020304, 32'h0, 4'hF, 0, 0);
    do_write(32'h303, 0, 0, 1, 1, 0, 32'h5A000000, 32'h0, 4'h8, 0, 0);
    do_read(32'h303, 0, 0, 0);
    chk("byte_wr_beats", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) chk("byte_wr_word", rx_q[0], 32'h5A020304);

    // write-back and refill of the same line, beats colliding word-for-word
    do_write(32'h400, 3, 2, 4, 1, 0, 32'hC0, 32'h1, 4'hF, 0, 0);
    fork
      do_write(32'h400, 3, 2, 4, 1, 0, 32'hD0, 32'h1, 4'hF, 0, 1);
      do_read(32'h400, 3, 2, 0);
    join
    chk("rbw_beats", 32'(rx_q.size()), 32'd4);
    for (int i = 0; i < rx_q.size(); i++) chk("rbw_old_data", rx_q[i], 32'hC0 + 32'(i));
    do_read(32'h400, 3, 2, 0);
    for (int i = 0; i < rx_q.size(); i++) chk("rbw_new_data", rx_q[i], 32'hD0 + 32'(i));

    // address wrap at the top of memory; high address bits ignored
    do_write(32'h3FFC, 1, 2, 2, 1, 0, 32'hE0, 32'h1, 4'hF, 0, 0);
    do_read(32'hF0003FFC, 1, 2, 0);
    chk("wrap_beats", 32'(rx_q.size()), 32'd2);
    if (rx_q.size() == 2) begin
      chk("wrap_top", rx_q[0], 32'hE0);
      chk("wrap_bottom", rx_q[1], 32'hE1);
    end

    // randomized concurrent traffic in a preloaded window
    do_write(32'h0, 63, 2, 64, 1, 1, 32'h0, 32'h0, 4'hF, 0, 0);
    for (int it = 0; it < 40; it++) begin
      automatic int wlen = $urandom_range(0, 7);
      automatic int nb = wlen + 1;
      automatic bit sl = 1'($urandom_range(0, 1));
      automatic int rlen = $urandom_range(0, 7);
      automatic logic [31:0] wa = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 200));
      automatic logic [31:0] ra = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 200));
      if ($urandom_range(0, 1) == 1) begin
        nb = $urandom_range(1, wlen + 1);
        sl = 1;
      end
      fork
        do_write(wa, wlen, $urandom_range(0, 2), nb, sl, 1, 32'h0, 32'h0, 4'h0, 1, $urandom_range(0, 2));
        do_read(ra, rlen, $urandom_range(0, 2), 2);
      join
    end

    // reset during beat 5 of a read
    r_addr = 32'h100; r_length = 8'd15; r_size = 3'd2; r_req = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!r_rdy && k < 200);
    @(posedge clk);
    #1 r_req = 1'b0;
    r_data_ready = 1'b1;
    cnt = 0;
    k = 0;
    while (cnt < 4 && k < 200) begin
      @(negedge clk);
      if (r_valid && r_data_ready) cnt++;
      @(posedge clk);
      #1;
      k++;
    end
    if (cnt < 4) tmo("reset_read_setup");
    chk("pre_reset_r_valid", 32'(r_valid), 32'h1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_r_valid", 32'(r_valid), 32'h0);
    chk("mid_rst_r_data", r_data, 32'h0);
    chk("mid_rst_r_last", 32'(r_last), 32'h0);
    r_data_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // reset during a write burst
    w_addr = 32'h500; w_length = 8'd7; w_size = 3'd2; w_strb = 4'hF; w_req = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!w_rdy && k < 200);
    @(posedge clk);
    #1 w_req = 1'b0;
    cnt = 0;
    k = 0;
    while (cnt < 3 && k < 200) begin
      w_valid = 1'b1;
      w_data = 32'h77 + 32'(cnt);
      @(negedge clk);
      if (w_valid && w_ready) cnt++;
      @(posedge clk);
      #1;
      k++;
    end
    if (cnt < 3) tmo("reset_write_setup");
    rstn = 1'b0;
    w_valid = 1'b0;
    #1;
    chk("mid_rst_w_ready", 32'(w_ready), 32'h0);
    chk("mid_rst_w_finish", 32'(w_finish), 32'h0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (w_finish) cnt++;
    end
    chk("no_finish_after_reset", 32'(cnt), 32'h0);
    @(posedge clk);
    #1;
    do_read(32'h500, 2, 2, 0);
    chk("rst_kept_beats", 32'(rx_q.size()), 32'd3);
    if (rx_q.size() == 3) chk("rst_kept_word2", rx_q[2], 32'h79);

    // fresh read after reset
    do_read(32'h100, 15, 2, 0);
    chk("post_rst_beats", 32'(rx_q.size()), 32'd16);
    chk("post_rst_latency", 32'(rd_first), 32'd2);
    if (rx_q.size() == 16) chk("post_rst_last_data", rx_q[15], 32'hAF);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
